// File: rtl/i2c_cfg_slave.sv
// i2c_cfg_slave: I2C/SCCB camera-side responder with a 256x8 register file and a write monitor strobe
module i2c_cfg_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h21
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        I2C_SCLK,
    inout  wire         I2C_SDAT,
    output logic        wr_valid,
    output logic [7:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic [15:0] wr_count,
    output logic        busy
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_DEV,
        S_ACK_DEV,
        S_SUB,
        S_ACK_SUB,
        S_WR,
        S_ACK_WR,
        S_RD,
        S_RD_ACK,
        S_IGNORE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        rw_q, rw_d;
    logic [7:0]  ptr_q, ptr_d;
    logic        sda_oe_q, sda_oe_d;
    logic        wr_valid_q, wr_valid_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic [15:0] wr_count_q, wr_count_d;
    logic        busy_q, busy_d;
    logic        reg_we;

    logic        scl_s1_q, scl_s2_q, scl_p_q;
    logic        sda_s1_q, sda_s2_q, sda_p_q;
    logic        scl_rise, scl_fall, start_ev, stop_ev;

    logic [7:0]  regs [256];
    logic [7:0]  rd_byte;
    logic [2:0]  bit_idx;

    // Bus lines idle high, so the synchronizers reset to 1 to avoid phantom edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            scl_p_q  <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
            sda_p_q  <= 1'b1;
        end else begin
            scl_s1_q <= I2C_SCLK;
            scl_s2_q <= scl_s1_q;
            scl_p_q  <= scl_s2_q;
            sda_s1_q <= I2C_SDAT;
            sda_s2_q <= sda_s1_q;
            sda_p_q  <= sda_s2_q;
        end
    end

    assign scl_rise = scl_s2_q & ~scl_p_q;
    assign scl_fall = ~scl_s2_q & scl_p_q;
    assign start_ev = scl_s2_q & scl_p_q & sda_p_q & ~sda_s2_q;
    assign stop_ev  = scl_s2_q & scl_p_q & ~sda_p_q & sda_s2_q;

    assign rd_byte  = regs[ptr_q];
    assign bit_idx  = ~cnt_q[2:0];

    assign I2C_SDAT = sda_oe_q ? 1'b0 : 1'bz;
    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign wr_count = wr_count_q;
    assign busy     = busy_q;

    // Protocol FSM: bus events override everything, otherwise act on SCL edges per state
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        rw_d       = rw_q;
        ptr_d      = ptr_q;
        sda_oe_d   = sda_oe_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_count_d = wr_count_q;
        busy_d     = busy_q;
        reg_we     = 1'b0;
        if (stop_ev) begin
            state_d  = S_IDLE;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_ev) begin
            state_d  = S_DEV;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
        end else begin
            unique case (state_q)
                S_DEV, S_SUB, S_WR: begin
                    if (scl_rise) begin
                        shreg_d = {shreg_q[6:0], sda_s2_q};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        cnt_d    = 4'd0;
                        sda_oe_d = 1'b1;
                        if (state_q == S_DEV) begin
                            if (shreg_q[7:1] == SLAVE_ADDR) begin
                                state_d = S_ACK_DEV;
                                rw_d    = shreg_q[0];
                                busy_d  = 1'b1;
                            end else begin
                                state_d  = S_IGNORE;
                                sda_oe_d = 1'b0;
                            end
                        end else if (state_q == S_SUB) begin
                            ptr_d   = shreg_q;
                            state_d = S_ACK_SUB;
                        end else begin
                            reg_we     = 1'b1;
                            wr_valid_d = 1'b1;
                            wr_addr_d  = ptr_q;
                            wr_data_d  = shreg_q;
                            wr_count_d = (wr_count_q == 16'hFFFF) ? wr_count_q : wr_count_q + 16'd1;
                            ptr_d      = ptr_q + 8'd1;
                            state_d    = S_ACK_WR;
                        end
                    end
                end
                S_ACK_DEV, S_ACK_SUB, S_ACK_WR: begin
                    if (scl_fall) begin
                        cnt_d    = 4'd0;
                        state_d  = (state_q != S_ACK_DEV) ? S_WR : (rw_q ? S_RD : S_SUB);
                        sda_oe_d = (state_q == S_ACK_DEV && rw_q) ? ~rd_byte[7] : 1'b0;
                    end
                end
                S_RD: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        sda_oe_d = cnt_q[3] ? 1'b0 : ~rd_byte[bit_idx];
                        state_d  = cnt_q[3] ? S_RD_ACK : S_RD;
                        cnt_d    = cnt_q[3] ? 4'd0 : cnt_q;
                    end
                end
                S_RD_ACK: begin
                    if (scl_rise) begin
                        ptr_d   = ptr_q + 8'd1;
                        state_d = sda_s2_q ? S_IGNORE : S_RD;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and output registers; reset releases SDA asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            shreg_q    <= 8'd0;
            rw_q       <= 1'b0;
            ptr_q      <= 8'd0;
            sda_oe_q   <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= 8'd0;
            wr_data_q  <= 8'd0;
            wr_count_q <= 16'd0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            rw_q       <= rw_d;
            ptr_q      <= ptr_d;
            sda_oe_q   <= sda_oe_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_count_q <= wr_count_d;
            busy_q     <= busy_d;
        end
    end

    // Register file behaves as RAM: written on accepted bytes, never cleared
    always_ff @(posedge clk) begin
        if (reg_we) regs[ptr_q] <= shreg_q;
    end

endmodule

// File: tb/tb_i2c_cfg_slave.sv
// tb_i2c_cfg_slave: directed bus-master bench for i2c_cfg_slave
module tb_i2c_cfg_slave;

    localparam int Q = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scl = 1'b1;
    logic        m_low = 1'b0;
    wire         sda;
    logic        wr_valid;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [15:0] wr_count;
    logic        busy;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          dut_low = 0;
    logic [15:0] sq[$];

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_cfg_slave dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .I2C_SCLK (scl),
        .I2C_SDAT (sda),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_count (wr_count),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Record write strobes and count cycles where the responder pulls SDA low
    always @(negedge clk) begin
        if (wr_valid) sq.push_back({wr_addr, wr_data});
        if (sda === 1'b0 && !m_low) dut_low++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_bit(input logic b, output logic r);
        tick(Q); m_low = ~b; tick(Q); scl = 1'b1; tick(Q); r = sda; tick(Q); scl = 1'b0;
    endtask

    task automatic bus_start;
        tick(Q); m_low = 1'b0; tick(Q); scl = 1'b1; tick(Q); m_low = 1'b1; tick(Q); scl = 1'b0;
    endtask

    task automatic bus_stop;
        tick(Q); m_low = 1'b1; tick(Q); scl = 1'b1; tick(Q); m_low = 1'b0; tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], r);
        bus_bit(1'b1, ack);
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] b);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, r);
            b[i] = r;
        end
        bus_bit(mack, r);
    endtask

    task automatic test_reset;
        n_cmp++; if (wr_valid !== 1'b0) begin n_bad++; $display("FAIL rst_wr_valid got %h want 0", wr_valid); end
        n_cmp++; if (wr_addr !== 8'h00) begin n_bad++; $display("FAIL rst_wr_addr got %h want 00", wr_addr); end
        n_cmp++; if (wr_data !== 8'h00) begin n_bad++; $display("FAIL rst_wr_data got %h want 00", wr_data); end
        n_cmp++; if (wr_count !== 16'h0) begin n_bad++; $display("FAIL rst_wr_count got %h want 0000", wr_count); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %h want 0", busy); end
        n_cmp++; if (sda !== 1'b1) begin n_bad++; $display("FAIL rst_sda got %b want 1", sda); end
    endtask

    task automatic test_single_write;
        logic a0, a1, a2;
        sq.delete();
        bus_start; send_byte(8'h42, a0);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL sw_busy_on got %h want 1", busy); end
        send_byte(8'h12, a1); send_byte(8'h80, a2); bus_stop; tick(4);
        n_cmp++; if ({a0, a1, a2} !== 3'b000) begin n_bad++; $display("FAIL sw_acks got %b want 000", {a0, a1, a2}); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL sw_busy_off got %h want 0", busy); end
        n_cmp++; if (wr_count !== 16'd1) begin n_bad++; $display("FAIL sw_count got %0d want 1", wr_count); end
        n_cmp++; if (sq.size() !== 1) begin n_bad++; $display("FAIL sw_strobes got %0d want 1", sq.size()); end
        n_cmp++; if (sq.size() > 0 && sq[0] !== 16'h1280) begin n_bad++; $display("FAIL sw_strobe0 got %h want 1280", sq[0]); end
        n_cmp++; if ({wr_addr, wr_data} !== 16'h1280) begin n_bad++; $display("FAIL sw_hold got %h want 1280", {wr_addr, wr_data}); end
    endtask

    task automatic test_burst_wrap;
        logic [4:0] a;
        sq.delete();
        bus_start; send_byte(8'h42, a[4]); send_byte(8'hFE, a[3]);
        send_byte(8'hA1, a[2]); send_byte(8'hA2, a[1]); send_byte(8'hA3, a[0]); bus_stop; tick(4);
        n_cmp++; if (a !== 5'b0) begin n_bad++; $display("FAIL bw_acks got %b want 00000", a); end
        n_cmp++; if (sq.size() !== 3) begin n_bad++; $display("FAIL bw_strobes got %0d want 3", sq.size()); end
        n_cmp++; if (sq.size() > 0 && sq[0] !== 16'hFEA1) begin n_bad++; $display("FAIL bw_strobe0 got %h want FEA1", sq[0]); end
        n_cmp++; if (sq.size() > 1 && sq[1] !== 16'hFFA2) begin n_bad++; $display("FAIL bw_strobe1 got %h want FFA2", sq[1]); end
        n_cmp++; if (sq.size() > 2 && sq[2] !== 16'h00A3) begin n_bad++; $display("FAIL bw_strobe2 got %h want 00A3", sq[2]); end
        n_cmp++; if (wr_count !== 16'd4) begin n_bad++; $display("FAIL bw_count got %0d want 4", wr_count); end
    endtask

    task automatic test_addr_mismatch;
        logic a0, a1, a2, a3, a4;
        int lows;
        sq.delete();
        lows = dut_low;
        bus_start; send_byte(8'h44, a0);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL am_busy got %h want 0", busy); end
        send_byte(8'h12, a1); bus_stop; tick(4);
        n_cmp++; if ({a0, a1} !== 2'b11) begin n_bad++; $display("FAIL am_nacks got %b want 11", {a0, a1}); end
        n_cmp++; if (dut_low !== lows) begin n_bad++; $display("FAIL am_sda_low got %0d want %0d", dut_low, lows); end
        n_cmp++; if (sq.size() !== 0) begin n_bad++; $display("FAIL am_strobes got %0d want 0", sq.size()); end
        bus_start; send_byte(8'h42, a2); send_byte(8'h13, a3); send_byte(8'h5A, a4); bus_stop; tick(4);
        n_cmp++; if ({a2, a3, a4} !== 3'b000) begin n_bad++; $display("FAIL am_next_acks got %b want 000", {a2, a3, a4}); end
        n_cmp++; if (sq.size() !== 1 || sq[0] !== 16'h135A) begin n_bad++; $display("FAIL am_next_strobe got %0d/%h want 1/135A", sq.size(), sq.size() > 0 ? sq[0] : 16'h0); end
        n_cmp++; if (wr_count !== 16'd5) begin n_bad++; $display("FAIL am_count got %0d want 5", wr_count); end
    endtask

    task automatic test_repeated_start_read;
        logic [3:0] a;
        logic [7:0] d0, d1;
        int lows;
        sq.delete();
        bus_start; send_byte(8'h42, a[3]); send_byte(8'h12, a[2]);
        bus_start; send_byte(8'h43, a[1]);
        recv_byte(1'b0, d0); recv_byte(1'b1, d1);
        lows = dut_low; tick(2 * Q);
        n_cmp++; if (dut_low !== lows || sda !== 1'b1) begin n_bad++; $display("FAIL rd_release got %0d/%b want %0d/1", dut_low, sda, lows); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rd_busy got %h want 1", busy); end
        bus_stop; tick(4);
        n_cmp++; if (a[3:1] !== 3'b000) begin n_bad++; $display("FAIL rd_acks got %b want 000", a[3:1]); end
        n_cmp++; if (d0 !== 8'h80) begin n_bad++; $display("FAIL rd_byte0 got %h want 80", d0); end
        n_cmp++; if (d1 !== 8'h5A) begin n_bad++; $display("FAIL rd_byte1 got %h want 5A", d1); end
        bus_start; send_byte(8'h42, a[3]); send_byte(8'hFF, a[2]);
        bus_start; send_byte(8'h43, a[1]);
        recv_byte(1'b0, d0); recv_byte(1'b1, d1); bus_stop; tick(4);
        n_cmp++; if ({d0, d1} !== 16'hA2A3) begin n_bad++; $display("FAIL rd_wrap got %h want A2A3", {d0, d1}); end
        n_cmp++; if (sq.size() !== 0) begin n_bad++; $display("FAIL rd_strobes got %0d want 0", sq.size()); end
    endtask

    task automatic test_stop_partial;
        logic a0, a1, a2, a3, a4, r;
        sq.delete();
        bus_start; send_byte(8'h42, a0); send_byte(8'h12, a1);
        bus_bit(1'b1, r); bus_bit(1'b0, r); bus_bit(1'b1, r); bus_bit(1'b1, r); bus_bit(1'b0, r);
        bus_stop; tick(4);
        n_cmp++; if (sq.size() !== 0) begin n_bad++; $display("FAIL sp_strobes got %0d want 0", sq.size()); end
        n_cmp++; if (wr_count !== 16'd5) begin n_bad++; $display("FAIL sp_count got %0d want 5", wr_count); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL sp_busy got %h want 0", busy); end
        bus_start; send_byte(8'h42, a2); send_byte(8'h20, a3); send_byte(8'h77, a4); bus_stop; tick(4);
        n_cmp++; if ({a0, a1, a2, a3, a4} !== 5'b0) begin n_bad++; $display("FAIL sp_acks got %b want 00000", {a0, a1, a2, a3, a4}); end
        n_cmp++; if (sq.size() !== 1 || sq[0] !== 16'h2077) begin n_bad++; $display("FAIL sp_next_strobe got %0d/%h want 1/2077", sq.size(), sq.size() > 0 ? sq[0] : 16'h0); end
        n_cmp++; if (wr_count !== 16'd6) begin n_bad++; $display("FAIL sp_next_count got %0d want 6", wr_count); end
    endtask

    task automatic test_reset_mid_ack;
        logic a0, a1, a2, a3, a4, r;
        logic [7:0] d;
        sq.delete();
        bus_start; send_byte(8'h42, a0); send_byte(8'h07, a1);
        for (int i = 7; i >= 0; i--) bus_bit(i[0], r);
        tick(Q); m_low = 1'b0; tick(Q); scl = 1'b1; tick(Q / 2);
        n_cmp++; if (sda !== 1'b0) begin n_bad++; $display("FAIL ra_ack_driven got %b want 0", sda); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (sda !== 1'b1) begin n_bad++; $display("FAIL ra_sda_async got %b want 1", sda); end
        tick(2);
        test_reset;
        rst_n = 1'b1; tick(4);
        bus_start; send_byte(8'h43, a2); recv_byte(1'b1, d); bus_stop; tick(4);
        n_cmp++; if (d !== 8'hA3) begin n_bad++; $display("FAIL ra_ptr_reset got %h want A3", d); end
        sq.delete();
        bus_start; send_byte(8'h42, a3); send_byte(8'h05, a4); send_byte(8'hC3, r); bus_stop; tick(4);
        n_cmp++; if ({a0, a1, a2, a3, a4, r} !== 6'b0) begin n_bad++; $display("FAIL ra_acks got %b want 000000", {a0, a1, a2, a3, a4, r}); end
        n_cmp++; if (sq.size() !== 1 || sq[0] !== 16'h05C3) begin n_bad++; $display("FAIL ra_strobe got %0d/%h want 1/05C3", sq.size(), sq.size() > 0 ? sq[0] : 16'h0); end
        n_cmp++; if (wr_count !== 16'd1) begin n_bad++; $display("FAIL ra_count got %0d want 1", wr_count); end
    endtask

    initial begin
        tick(3);
        rst_n = 1'b1;
        tick(4);
        test_reset;
        test_single_write;
        test_burst_wrap;
        test_addr_mismatch;
        test_repeated_start_read;
        test_stop_partial;
        test_reset_mid_ack;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
